// File: rtl/q_loader_pkg.sv
// Shared types and sizes for the Q-vector loader.
package q_loader_pkg;

    localparam int ELEM_W   = 8;
    localparam int HEAD_DIM = 64;
    localparam int VEC_W    = HEAD_DIM * ELEM_W;

    // One Q vector as a buffer row; element 0 sits in the LSBs
    typedef logic [VEC_W-1:0] Q_VECTOR_T;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PAD,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/q_beat_assembler.sv
// Collects in-order memory beats into one Q vector and hands complete vectors
// (or zero pad rows) to a single output register with a valid/ready handshake.
module q_beat_assembler
    import q_loader_pkg::*;
#(
    parameter int MEM_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_valid,
    input  logic [MEM_W-1:0] beat_data,
    input  logic             pad_req,
    input  logic             out_ready,
    output logic             asm_move,
    output logic             row_load,
    output logic             row_xfer,
    output logic             out_valid,
    output Q_VECTOR_T        out_data
);

    localparam int BEATS = VEC_W / MEM_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BW-1:0] beat_cnt;
    Q_VECTOR_T     asm_data;
    Q_VECTOR_T     merged;
    logic          asm_full;
    logic          final_beat;
    logic          out_free;
    logic          pad_load;

    // Current assembly contents with the arriving beat dropped into its slot
    always_comb begin
        merged = asm_data;
        merged[int'(beat_cnt) * MEM_W +: MEM_W] = beat_data;
    end

    // Handshake decode: a finished vector moves out as soon as the output slot frees,
    // bypassing the assembly register when the final beat arrives into a free slot
    always_comb begin
        final_beat = beat_valid && (beat_cnt == BW'(BEATS - 1));
        row_xfer   = out_valid && out_ready;
        out_free   = !out_valid || out_ready;
        asm_move   = out_free && (asm_full || final_beat);
        pad_load   = out_free && pad_req && !asm_move;
        row_load   = asm_move || pad_load;
    end

    // Assembly register: beats fill low to high; full holds a vector waiting for the output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            asm_full <= 1'b0;
        end else begin
            if (beat_valid) begin
                asm_data <= merged;
                beat_cnt <= final_beat ? '0 : beat_cnt + BW'(1);
            end
            if (asm_move) begin
                asm_full <= 1'b0;
            end else if (final_beat) begin
                asm_full <= 1'b1;
            end
        end
    end

    // Output register: reloads in the same cycle its row is taken, so one row per cycle max
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (asm_move) begin
            out_valid <= 1'b1;
            out_data  <= asm_full ? asm_data : merged;
        end else if (pad_load) begin
            out_valid <= 1'b1;
            out_data  <= '0;
        end else if (row_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/q_loader.sv
// Fetches num_vectors Q vectors as memory beats, writes them into the Q buffer
// one row at a time, and pads the last tile with zero rows to a NUM_ROWS boundary.
module q_loader
    import q_loader_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int MEM_W    = 64,
    parameter int ADDR_W   = 32,
    parameter int MAX_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_vectors,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [MEM_W-1:0]  mem_resp_data,
    output logic              q_write_enable,
    input  logic              q_sram_ready,
    output Q_VECTOR_T         q_write_data
);

    localparam int BEATS = VEC_W / MEM_W;
    localparam int STEP  = MEM_W / 8;
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam int IW    = $clog2(BEATS + 1);
    localparam int TW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    loader_state_t state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       num_vec;
    logic [15:0]       vec_iss;
    logic [15:0]       vec_cnt;
    logic [15:0]       rows_written;
    logic [IW-1:0]     iss_cnt;
    logic [IW-1:0]     issue_idx;
    logic [OW-1:0]     outstanding;
    logic [TW-1:0]     tile_cnt;
    logic              beat_valid;
    logic              req_fire;
    logic              last_issue;
    logic              pad_req;
    logic              asm_move;
    logic              row_load;
    logic              row_xfer;

    // Request gating: bounded outstanding, at most one vector being requested,
    // and nothing new while both the assembly and output registers are occupied
    always_comb begin
        beat_valid    = mem_resp_valid && (state == ST_FETCH);
        mem_req_valid = (state == ST_FETCH) && (outstanding < OW'(MAX_OUT)) &&
                        ((iss_cnt < IW'(BEATS)) || asm_move) && (vec_iss < num_vec);
        mem_req_addr  = addr;
        req_fire      = mem_req_valid && mem_req_ready;
        issue_idx     = asm_move ? '0 : iss_cnt;
        last_issue    = (issue_idx == IW'(BEATS - 1));
        pad_req       = (state == ST_PAD) && (tile_cnt != '0);
    end

    q_beat_assembler #(
        .MEM_W (MEM_W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (beat_valid),
        .beat_data  (mem_resp_data),
        .pad_req    (pad_req),
        .out_ready  (q_sram_ready),
        .asm_move   (asm_move),
        .row_load   (row_load),
        .row_xfer   (row_xfer),
        .out_valid  (q_write_enable),
        .out_data   (q_write_data)
    );

    // Control FSM plus request, outstanding, tile and row bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            addr         <= '0;
            num_vec      <= '0;
            vec_iss      <= '0;
            vec_cnt      <= '0;
            rows_written <= '0;
            iss_cnt      <= '0;
            outstanding  <= '0;
            tile_cnt     <= '0;
        end else begin
            done <= 1'b0;

            if (req_fire) begin
                addr <= addr + ADDR_W'(STEP);
                if (last_issue) begin
                    vec_iss <= vec_iss + 16'd1;
                end
            end

            // Beat issue count belongs to the vector in the assembly register
            if (asm_move) begin
                iss_cnt <= req_fire ? IW'(1) : '0;
            end else if (req_fire) begin
                iss_cnt <= iss_cnt + IW'(1);
            end

            case ({req_fire, beat_valid})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            // Position of the next loaded row inside its tile
            if (row_load) begin
                tile_cnt <= (tile_cnt == TW'(NUM_ROWS - 1)) ? '0 : tile_cnt + TW'(1);
            end

            if (row_xfer) begin
                rows_written <= rows_written + 16'd1;
                if (state == ST_FETCH) begin
                    vec_cnt <= vec_cnt + 16'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        addr         <= base_addr;
                        num_vec      <= num_vectors;
                        vec_iss      <= '0;
                        vec_cnt      <= '0;
                        rows_written <= '0;
                        iss_cnt      <= '0;
                        outstanding  <= '0;
                        tile_cnt     <= '0;
                        state        <= (num_vectors == 16'd0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (row_xfer && (vec_cnt == num_vec - 16'd1)) begin
                        state <= (tile_cnt == '0) ? ST_DONE : ST_PAD;
                    end
                end
                ST_PAD: begin
                    if ((tile_cnt == '0) && (!q_write_enable || row_xfer)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
